// File: rtl/csa_operand_packer.sv
// Operand packer for the N-operand carry-save adder: collects W-bit operands
// into a flat lane bus and keeps a running reference sum and a sticky overflow flag.
module csa_operand_packer #(
  parameter int N = 25,
  parameter int E = 3,
  parameter int W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*W-1:0]             out_bus,
  output logic [W+E:0]               out_ref,
  output logic                       out_ovf,
  output logic [$clog2(N+1)-1:0]     out_cnt
);

  localparam int RW = W + E + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state_q, state_d;
  logic [N*W-1:0]  bus_q, bus_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW:0]     sum_ext;

  // The operand count doubles as the write lane index: both start at 0 and
  // advance together on every accepted operand.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    ref_d   = ref_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    sum_ext = {1'b0, ref_q} + (RW+1)'(in_data);
    if (state_q == FILL) begin
      if (in_valid) begin
        bus_d[cnt_q*W +: W] = in_data;
        ref_d               = sum_ext[RW-1:0];
        ovf_d               = ovf_q | sum_ext[RW];
        cnt_d               = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1) || in_last) state_d = HOLD;
      end
    end else begin
      if (out_ready) begin
        state_d = FILL;
        bus_d   = '0;
        ref_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      bus_q   <= '0;
      ref_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      ref_q   <= ref_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_bus   = bus_q;
  assign out_ref   = ref_q;
  assign out_ovf   = ovf_q;
  assign out_cnt   = cnt_q;

endmodule
